// File: rtl/sched_pkg.sv
// Shared types and constants for the per-port read scheduler.
// Queue geometry, bypass counter width and the grant FSM states.
package sched_pkg;

    localparam int NUM_PRIO = 8;
    localparam int PRIO_W   = 3;
    localparam int PORT_W   = 4;
    localparam int BYP_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/prio_pick.sv
// Next-queue selector: strict priority with starvation override.
// A starved queue wins (lowest index first), else highest eligible.
module prio_pick
    import sched_pkg::*;
(
    input  logic [NUM_PRIO-1:0] eligible,
    input  logic [NUM_PRIO-1:0] starved,
    output logic [PRIO_W-1:0]   sel,
    output logic                any
);

    // Later loop iterations overwrite earlier ones, so the scan
    // direction decides which end of the vector wins.
    always_comb begin
        sel = '0;
        any = |eligible;
        if (|starved) begin
            for (int i = NUM_PRIO - 1; i >= 0; i--) begin
                if (starved[i]) sel = PRIO_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_PRIO; i++) begin
                if (eligible[i]) sel = PRIO_W'(i);
            end
        end
    end

endmodule

// File: rtl/port_scheduler.sv
// Per-output-port read scheduler for the shared packet buffer.
// Snoops buffer writes, counts per-queue packets, issues read grants.
module port_scheduler
    import sched_pkg::*;
#(
    parameter int PORT_ID      = 0,
    parameter int CNT_W        = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wea,
    input  logic [PORT_W-1:0]  dest_port,
    input  logic [PRIO_W-1:0]  wr_prio,
    input  logic               port_ready,
    input  logic               rd_done,
    output logic               port_rea,
    output logic [PRIO_W-1:0]  port_priority,
    output logic               busy,
    output logic [CNT_W+2:0]   backlog,
    output logic               ovf_err
);

    state_e                state_q, state_d;
    logic [PRIO_W-1:0]     prio_q, prio_d;
    logic [CNT_W-1:0]      cnt_q [NUM_PRIO];
    logic [CNT_W-1:0]      cnt_d [NUM_PRIO];
    logic [BYP_W-1:0]      byp_q [NUM_PRIO];
    logic [BYP_W-1:0]      byp_d [NUM_PRIO];
    logic [CNT_W+2:0]      backlog_q, backlog_d;
    logic                  ovf_q, ovf_d;

    logic                  enq;
    logic                  granting;
    logic [NUM_PRIO-1:0]   inc_v, dec_v;
    logic [NUM_PRIO-1:0]   eligible, starved;
    logic [PRIO_W-1:0]     sel;
    logic                  any;

    assign enq      = wea && (dest_port == PORT_W'(PORT_ID));
    assign granting = (state_q == GRANT);

    // Per-queue enqueue and grant strobes for this cycle.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            inc_v[i] = enq && (wr_prio == PRIO_W'(i));
            dec_v[i] = granting && (prio_q == PRIO_W'(i));
        end
    end

    // Eligibility and starvation flags feeding the selector.
    always_comb begin
        eligible = '0;
        starved  = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            eligible[i] = (cnt_q[i] != '0);
            starved[i]  = eligible[i] &&
                          (byp_q[i] >= BYP_W'(STARVE_LIMIT));
        end
    end

    prio_pick u_pick (
        .eligible (eligible),
        .starved  (starved),
        .sel      (sel),
        .any      (any)
    );

    // Queue counters, saturation flag and the registered backlog sum.
    always_comb begin
        ovf_d     = ovf_q;
        backlog_d = '0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                if (&cnt_q[i]) ovf_d = 1'b1;
                else           cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_v[i] && !inc_v[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            backlog_d = backlog_d + {3'b000, cnt_d[i]};
        end
    end

    // Bypass ageing: waiting queues age on each grant, empty ones reset.
    always_comb begin
        for (int i = 0; i < NUM_PRIO; i++) begin
            byp_d[i] = byp_q[i];
            if (granting) begin
                if (dec_v[i])
                    byp_d[i] = '0;
                else if (eligible[i] && (byp_q[i] != '1))
                    byp_d[i] = byp_q[i] + 1'b1;
            end
            if (cnt_d[i] == '0) byp_d[i] = '0;
        end
    end

    // Grant FSM: pick in IDLE, pulse in GRANT, hold until read-out done.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        unique case (state_q)
            IDLE: begin
                if (any && port_ready) begin
                    state_d = GRANT;
                    prio_d  = sel;
                end
            end
            GRANT: state_d = WAIT;
            WAIT: begin
                if (rd_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= '0;
            backlog_q <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < NUM_PRIO; i++) begin
                cnt_q[i] <= '0;
                byp_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            backlog_q <= backlog_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < NUM_PRIO; i++) begin
                cnt_q[i] <= cnt_d[i];
                byp_q[i] <= byp_d[i];
            end
        end
    end

    assign port_rea      = (state_q == GRANT);
    assign busy          = (state_q != IDLE);
    assign port_priority = prio_q;
    assign backlog       = backlog_q;
    assign ovf_err       = ovf_q;

endmodule
